// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - fetch-side instruction memory filled from a byte stream
module inst_mem_loader #(
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_data,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    output logic              loaded,
    output logic              load_err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [1:0] S_HDR  = 2'd0;
    localparam logic [1:0] S_BODY = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [ADDR_W:0] CNT_MAX = '1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    // Instruction storage; deliberately not reset so a warm reset keeps the image.
    logic [31:0] mem [0:DEPTH-1];

    logic [1:0]        state_q,    state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       shift_q,    shift_d;
    logic [ADDR_W:0]   hdr_cnt_q,  hdr_cnt_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              load_err_q, load_err_d;
    logic [31:0]       inst_data_q, inst_data_d;

    logic              accept;
    logic              word_done;
    logic [31:0]       full_word;
    logic [ADDR_W:0]   word_cnt_inc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;

    // The byte stream is only open while collecting header or body bytes.
    assign load_ready = (state_q == S_HDR) || (state_q == S_BODY);
    assign loaded     = (state_q == S_RUN);
    assign load_err   = load_err_q;
    assign word_cnt   = word_cnt_q;
    assign inst_data  = inst_data_q;

    // A byte coinciding with load_start is dropped: the restart wins.
    assign accept       = load_valid && load_ready && !load_start;
    assign word_done    = accept && (byte_idx_q == 2'd3);
    assign full_word    = {shift_q, load_data};
    assign word_cnt_inc = (word_cnt_q == CNT_MAX) ? word_cnt_q : word_cnt_q + 1'b1;
    // word_cnt doubles as the body write index; both start at zero and advance together.
    assign mem_waddr    = word_cnt_q[ADDR_W-1:0];

    // Loader next-state: header/body byte assembly, counters and error flag.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        hdr_cnt_d  = hdr_cnt_q;
        word_cnt_d = word_cnt_q;
        load_err_d = load_err_q;
        mem_we     = 1'b0;

        if (load_start) begin
            // Restart discards any partial word and the previous load's status.
            state_d    = S_HDR;
            byte_idx_d = 2'd0;
            word_cnt_d = '0;
            load_err_d = 1'b0;
        end else if (accept) begin
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = {shift_q[15:0], load_data};
            if (word_done) begin
                if (state_q == S_HDR) begin
                    hdr_cnt_d  = full_word[ADDR_W:0];
                    word_cnt_d = '0;
                    state_d    = (full_word == 32'd0) ? S_RUN : S_BODY;
                    if (full_word > 32'(DEPTH)) begin
                        load_err_d = 1'b1;
                    end
                end else begin
                    // Words past the end of memory are counted but not stored.
                    mem_we     = (word_cnt_q < DEPTH_C);
                    word_cnt_d = word_cnt_inc;
                    if (word_cnt_inc == hdr_cnt_q) begin
                        state_d = S_RUN;
                    end
                end
            end
        end
    end

    // Fetch read port: memory word in RUN, nop (zero) otherwise.
    always_comb begin
        inst_data_d = 32'h0;
        if (state_q == S_RUN) begin
            inst_data_d = mem[inst_addr];
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HDR;
            byte_idx_q  <= 2'd0;
            shift_q     <= 24'h0;
            hdr_cnt_q   <= '0;
            word_cnt_q  <= '0;
            load_err_q  <= 1'b0;
            inst_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            hdr_cnt_q   <= hdr_cnt_d;
            word_cnt_q  <= word_cnt_d;
            load_err_q  <= load_err_d;
            inst_data_q <= inst_data_d;
        end
    end

    // Memory write port, driven only by the loader in BODY.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= full_word;
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - directed bench for inst_mem_loader
module tb_inst_mem_loader;

    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] inst_addr = '0;
    logic [31:0]       inst_data;
    logic              load_start = 1'b0;
    logic              load_valid = 1'b0;
    logic [7:0]        load_data = 8'h00;
    logic              load_ready;
    logic              loaded;
    logic              load_err;
    logic [ADDR_W:0]   word_cnt;

    int checks = 0;
    int errors = 0;

    inst_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_addr  (inst_addr),
        .inst_data  (inst_data),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .loaded     (loaded),
        .load_err   (load_err),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = b;
        @(posedge clk);
        #1 load_valid = 1'b0;
    endtask

    task automatic send_byte_gap(input logic [7:0] b);
        send_byte(b);
        @(negedge clk);
        load_data = 8'h5A;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic send_word_gap(input logic [31:0] w);
        send_byte_gap(w[31:24]);
        send_byte_gap(w[23:16]);
        send_byte_gap(w[15:8]);
        send_byte_gap(w[7:0]);
    endtask

    task automatic pulse_start;
        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        @(negedge clk);
        inst_addr = a;
        @(posedge clk);
        #1 chk(tag, inst_data, exp);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_loaded", {31'h0, loaded}, 32'h0);
        chk("rst_load_err", {31'h0, load_err}, 32'h0);
        chk("rst_word_cnt", {29'h0, word_cnt}, 32'h0);
        chk("rst_load_ready", {31'h0, load_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // Boot load of two words
        send_word(32'h0000_0002);
        send_word(32'hDEAD_BEEF);
        send_byte(8'h01);
        send_byte(8'h23);
        send_byte(8'h45);
        chk("boot_loaded_pre", {31'h0, loaded}, 32'h0);
        chk("boot_cnt_pre", {29'h0, word_cnt}, 32'h1);
        send_byte(8'h67);
        chk("boot_loaded", {31'h0, loaded}, 32'h1);
        chk("boot_cnt", {29'h0, word_cnt}, 32'h2);
        chk("boot_ready_run", {31'h0, load_ready}, 32'h0);
        read_chk("boot_rd0", 2'd0, 32'hDEAD_BEEF);
        read_chk("boot_rd1", 2'd1, 32'h0123_4567);

        // Bytes presented in RUN are ignored
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'hFF;
        repeat (6) @(posedge clk);
        #1 load_valid = 1'b0;
        chk("run_bytes_cnt", {29'h0, word_cnt}, 32'h2);
        chk("run_bytes_loaded", {31'h0, loaded}, 32'h1);
        read_chk("run_bytes_rd0", 2'd0, 32'hDEAD_BEEF);

        // Reload with a coincident byte on the load_start edge, then gapped stream
        @(negedge clk);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h55;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        load_valid = 1'b0;
        chk("reload_loaded", {31'h0, loaded}, 32'h0);
        chk("reload_cnt", {29'h0, word_cnt}, 32'h0);
        chk("reload_ready", {31'h0, load_ready}, 32'h1);
        chk("reload_nop", inst_data, 32'hDEAD_BEEF);
        @(posedge clk);
        #1 chk("reload_nop_hdr", inst_data, 32'h0);
        send_word_gap(32'h0000_0001);
        chk("reload_mid_loaded", {31'h0, loaded}, 32'h0);
        send_word_gap(32'hAABB_CCDD);
        chk("reload_done", {31'h0, loaded}, 32'h1);
        chk("reload_err", {31'h0, load_err}, 32'h0);
        chk("reload_cnt_done", {29'h0, word_cnt}, 32'h1);
        read_chk("reload_rd0", 2'd0, 32'hAABB_CCDD);
        read_chk("reload_rd1", 2'd1, 32'h0123_4567);

        // Asynchronous reset between edges while in RUN
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data", inst_data, 32'h0);
        chk("async_rst_loaded", {31'h0, loaded}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Abort mid-word by reset, then reload
        send_word(32'h0000_0002);
        send_byte(8'h99);
        send_byte(8'h88);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_cnt", {29'h0, word_cnt}, 32'h0);
        send_word(32'h0000_0001);
        send_word(32'h1122_3344);
        chk("abort_loaded", {31'h0, loaded}, 32'h1);
        read_chk("abort_rd0", 2'd0, 32'h1122_3344);
        read_chk("abort_rd1", 2'd1, 32'h0123_4567);

        // Empty program
        pulse_start();
        send_word(32'h0000_0000);
        chk("empty_loaded", {31'h0, loaded}, 32'h1);
        chk("empty_ready", {31'h0, load_ready}, 32'h0);
        chk("empty_cnt", {29'h0, word_cnt}, 32'h0);
        read_chk("empty_rd0", 2'd0, 32'h1122_3344);

        // Overflow: N=5 on a 4-word memory
        pulse_start();
        send_word(32'h0000_0005);
        chk("ovf_err_hdr", {31'h0, load_err}, 32'h1);
        chk("ovf_loaded_hdr", {31'h0, loaded}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            send_word(32'h1111_1111 * (i + 1));
        end
        chk("ovf_cnt4", {29'h0, word_cnt}, 32'h4);
        chk("ovf_loaded4", {31'h0, loaded}, 32'h0);
        send_word(32'h5555_5555);
        chk("ovf_loaded5", {31'h0, loaded}, 32'h1);
        chk("ovf_cnt5", {29'h0, word_cnt}, 32'h5);
        chk("ovf_err_sticky", {31'h0, load_err}, 32'h1);
        read_chk("ovf_rd0", 2'd0, 32'h1111_1111);
        read_chk("ovf_rd1", 2'd1, 32'h2222_2222);
        read_chk("ovf_rd2", 2'd2, 32'h3333_3333);
        read_chk("ovf_rd3", 2'd3, 32'h4444_4444);

        // load_start clears the sticky error
        pulse_start();
        chk("ovf_err_clr", {31'h0, load_err}, 32'h0);
        chk("ovf_clr_cnt", {29'h0, word_cnt}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Instruction-memory responder for the fetch stage. It serves the fetch unit's word-addressed instruction requests (inst_addr in, inst_data out) with a one-edge registered read. The memory is filled at boot, or on request, from a byte stream supplied by the serial receiver. Instruction memory is the only storage in the block; the loader FSM is the only writer.

Parameters:
ADDR_W, 17, word-address width; must match the fetch unit's inst_addr width.
DEPTH, 1<<ADDR_W, number of 32-bit words; words at or above DEPTH do not exist.

Ports:
clk  in  1  clock; every register updates on posedge.
rst  in  1  asynchronous, active-high reset.
inst_addr  in  ADDR_W  word address from fetch (byte PC[ADDR_W+1:2]).
inst_data  out  32  registered instruction word.
load_start  in  1  one-cycle pulse; begins a (re)load.
load_valid  in  1  byte-stream valid.
load_data  in  8  byte-stream payload.
load_ready  out  1  byte-stream ready; combinational from state.
loaded  out  1  high while in RUN.
load_err  out  1  sticky overflow flag; cleared by rst or load_start.
word_cnt  out  ADDR_W+1  words written by the current or last load.

Behaviour:
- Reset values: state=HDR, inst_data=0, loaded=0, load_err=0, word_cnt=0, byte index=0, header count=0. The reset does not clear memory contents.
- Byte handshake: a byte is accepted on a posedge where load_valid && load_ready. load_ready=1 only in HDR and BODY. load_valid while load_ready=0 has no effect.
- Byte order: big-endian. The first accepted byte of each 4-byte group is bits [31:24]. A 2-bit byte index wraps 3->0.
- FSM states: HDR, BODY, RUN.
- HDR: accept 4 bytes; the word formed is header count N (32 bits).
  - On the 4th byte: if N==0, go to RUN. Otherwise go to BODY with widx=0.
  - If N>DEPTH, set load_err=1 on the same edge.
- BODY: on each 4th byte, the word is {shift[23:0], load_data}.
  - If widx<DEPTH, write mem[widx] on that edge. Otherwise drop the word.
  - Increment widx and word_cnt. The increment saturates at 2^(ADDR_W+1)-1 and never wraps.
  - When the incremented count equals N (low ADDR_W+1 bits compared, with N clamped to DEPTH for writes), go to RUN on the same edge.
- RUN: loaded=1, load_ready=0.
  - Every posedge: inst_data <= mem[inst_addr]. Read latency is 1 edge; data is stable for capture by fetch on the following negedge.
  - Outside RUN: inst_data <= 32'h0, which is treated as a nop.
- load_start, in any state: on the next edge go to HDR; clear byte index, word_cnt, widx and load_err; loaded drops to 0.
  - A byte presented on the same edge as load_start is not accepted.
- Partial words: a partial word (byte index != 0) is discarded when load_start or rst occurs.
- Reset mid-load: outputs return to reset values immediately (asynchronous). Memory keeps the words already written.
- Read/write hazard: none. Reads and writes are never both enabled on the same edge, because writes occur only in BODY and reads only in RUN.
- inst_addr is used unmodified. Out-of-range addresses cannot occur when DEPTH=1<<ADDR_W.

Test Plan:
- Boot load: rst, then stream 00 00 00 02, DE AD BE EF, 01 23 45 67 → word_cnt=2 and loaded=1 after the 12th byte. Then inst_addr=0 gives inst_data=DEADBEEF and inst_addr=1 gives 01234567, each one edge later.
- Empty program: header 00 00 00 00 → loaded=1 on the edge after the 4th byte; load_ready=0; inst_data returns mem contents.
- Backpressure and gaps: load_valid toggling every other cycle, plus bytes driven while in RUN → only handshaked bytes count; bytes in RUN are ignored and mem is unchanged.
- Reload: in RUN pulse load_start, then stream N=1, AABBCCDD → loaded=0 during the load; after it, addr0 reads AABBCCDD and addr1 keeps its old value.
- Abort mid-word: assert rst after 2 body bytes, then reload N=1, 11223344 → addr0=11223344 and no stray write.
- Overflow: with ADDR_W=2 (DEPTH=4), header N=5 plus 5 words → load_err=1 at the header; words 0-3 are stored and word 4 is dropped; loaded=1 after the 5th word.
